// File: rtl/ascon_tag_verify_if.sv
// Tag-word stream between the tag source and ascon_tag_verify. The high tag word is sent first.
// Each word transfers on a clock edge where tag_valid and tag_ready are both high.
`timescale 1ns/1ps
interface ascon_tag_verify_if;
  logic [63:0] tag_data;
  logic        tag_valid;
  logic        tag_ready;

  modport master (output tag_data, output tag_valid, input tag_ready);
  modport slave  (input tag_data, input tag_valid, output tag_ready);
endinterface

// File: rtl/ascon_tag_verify.sv
// Forms the expected ASCON tag from the final state and the key, then compares it in constant time.
// Optional macro ASCON_TAG_ZEROIZE_EN clears the expected tag after a failed check.
`timescale 1ns/1ps
module ascon_tag_verify #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clock_i,
  input  logic                resetb_i,
  input  logic                start_i,
  input  logic [4:0][63:0]    state_i,
  input  logic [127:0]        key_i,
  ascon_tag_verify_if.slave   tag_if,
  output logic [127:0]        tag_o,
  output logic                done_o,
  output logic                tag_ok_o,
  output logic                error_o
);

  localparam int unsigned     CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit              TMO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0]   CNT_MAX = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV_HI = 2'd1,
    RECV_LO = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e        state_q;
  logic [127:0]  tag_q;
  logic [63:0]   acc_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          ok_q;
  logic          err_q;

  logic          recv_s;
  logic          hs_s;
  logic          expire_s;
  logic [63:0]   exp_word_s;
  logic [63:0]   acc_d;
  logic          unused_state_bits;

  assign recv_s     = (state_q == RECV_HI) || (state_q == RECV_LO);
  assign hs_s       = recv_s && tag_if.tag_valid;
  assign expire_s   = TMO_EN && (cnt_q == CNT_MAX);
  assign exp_word_s = (state_q == RECV_HI) ? tag_q[127:64] : tag_q[63:0];
  // The accumulator only ORs in differences, so one mismatching word is never "forgotten".
  assign acc_d      = acc_q | (tag_if.tag_data ^ exp_word_s);

  assign unused_state_bits = ^{state_i[2], state_i[1], state_i[0]};

  assign tag_if.tag_ready = recv_s;
  assign tag_o    = tag_q;
  assign done_o   = done_q;
  assign tag_ok_o = ok_q;
  assign error_o  = err_q;

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      tag_q   <= 128'd0;
      acc_q   <= 64'd0;
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            tag_q   <= {state_i[3] ^ key_i[127:64], state_i[4] ^ key_i[63:0]};
            acc_q   <= 64'd0;
            cnt_q   <= {CW{1'b0}};
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            state_q <= RECV_HI;
          end else begin
`ifdef ASCON_TAG_ZEROIZE_EN
            if ((state_q == DONE) && !ok_q) begin
              tag_q <= 128'd0;
              acc_q <= 64'd0;
            end else begin
              tag_q <= tag_q;
            end
`else
            tag_q <= tag_q;
`endif
          end
        end
        RECV_HI, RECV_LO: begin
          // A handshake takes priority over expiry in the same cycle.
          if (hs_s) begin
            acc_q <= acc_d;
            cnt_q <= {CW{1'b0}};
            if (state_q == RECV_HI) begin
              state_q <= RECV_LO;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              ok_q    <= (acc_d == 64'd0);
              err_q   <= 1'b0;
`ifdef ASCON_TAG_ZEROIZE_EN
              if (acc_d != 64'd0) begin
                tag_q <= 128'd0;
                acc_q <= 64'd0;
              end else begin
                tag_q <= tag_q;
              end
`endif
            end
          end else if (expire_s) begin
            state_q <= DONE;
            cnt_q   <= {CW{1'b0}};
            done_q  <= 1'b1;
            ok_q    <= 1'b0;
            err_q   <= 1'b1;
`ifdef ASCON_TAG_ZEROIZE_EN
            tag_q   <= 128'd0;
            acc_q   <= 64'd0;
`endif
          end else if (TMO_EN) begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_tag_verify.sv
// Directed self-checking bench for ascon_tag_verify (built with TIMEOUT_CYC=8).
`timescale 1ns/1ps
module tb_ascon_tag_verify;

  localparam logic [63:0]  X3  = 64'hc0c4757ca2646459;
  localparam logic [63:0]  X4  = 64'hf44a7ed98e1d9c83;
  localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [63:0]  THI = 64'hc0c5777fa661625e;
  localparam logic [63:0]  TLO = 64'hfc4374d28210928c;

  logic             clk;
  logic             resetb;
  logic             start;
  logic [4:0][63:0] st;
  logic [127:0]     key;
  logic [127:0]     tag_o;
  logic             done_o;
  logic             tag_ok_o;
  logic             error_o;
  logic [127:0]     fail_tag;
  int               total;
  int               bad;

  ascon_tag_verify_if tif ();

  ascon_tag_verify #(.TIMEOUT_CYC(8)) dut (
    .clock_i  (clk),
    .resetb_i (resetb),
    .start_i  (start),
    .state_i  (st),
    .key_i    (key),
    .tag_if   (tif),
    .tag_o    (tag_o),
    .done_o   (done_o),
    .tag_ok_o (tag_ok_o),
    .error_o  (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags packed as {done, ok, error, ready}.
  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk(tag, {124'd0, done_o, tag_ok_o, error_o, tif.tag_ready}, {124'd0, exp});
  endtask

  task automatic do_start(input logic [63:0] x3, input logic [63:0] x4, input logic [127:0] k);
    st[3] = x3;
    st[4] = x4;
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] w);
    tif.tag_valid = 1'b1;
    tif.tag_data  = w;
    step();
    tif.tag_valid = 1'b0;
    tif.tag_data  = 64'd0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetb = 1'b0;
    start = 1'b0;
    st[0] = 64'h1111111111111111;
    st[1] = 64'h2222222222222222;
    st[2] = 64'h3333333333333333;
    st[3] = 64'd0;
    st[4] = 64'd0;
    key = 128'd0;
    tif.tag_valid = 1'b0;
    tif.tag_data = 64'd0;
`ifdef ASCON_TAG_ZEROIZE_EN
    fail_tag = 128'd0;
`else
    fail_tag = {THI, TLO};
`endif

    step();
    step();
    chk("reset_tag", tag_o, 128'd0);
    chk_flags("reset_flags", 4'b0000);
    resetb = 1'b1;

    // Valid while idle must be ignored.
    tif.tag_valid = 1'b1;
    tif.tag_data = THI;
    step();
    tif.tag_valid = 1'b0;
    chk_flags("idle_ignore_valid", 4'b0000);

    // Matching tag.
    do_start(X3, X4, KEY);
    chk("match_tag", tag_o, {THI, TLO});
    chk_flags("match_recv_hi", 4'b0001);
    send(THI);
    chk_flags("match_recv_lo", 4'b0001);
    send(TLO);
    chk_flags("match_done", 4'b1100);
    step();
    chk_flags("match_done_held", 4'b1100);
    chk("match_tag_held", tag_o, {THI, TLO});

    // High word mismatch, restarted straight from DONE.
    do_start(X3, X4, KEY);
    chk_flags("mis_restart_clear", 4'b0001);
    send(THI ^ 64'd1);
    chk_flags("mis_lo_still_ready", 4'b0001);
    send(TLO);
    chk_flags("mis_done", 4'b1000);
    chk("mis_tag_at_done", tag_o, fail_tag);
    step();
    chk("mis_tag_after", tag_o, fail_tag);
    chk_flags("mis_done_held", 4'b1000);

    // Restart after failure with a new state: zero rate words, so tag == key.
    do_start(64'd0, 64'd0, 128'hfedcba98765432100123456789abcdef);
    chk_flags("restart_clear", 4'b0001);
    chk("restart_tag", tag_o, 128'hfedcba98765432100123456789abcdef);
    send(64'hfedcba9876543210);
    send(64'h0123456789abcdef);
    chk_flags("restart_ok", 4'b1100);

    // Gaps between words; a single valid cycle must capture exactly once.
    do_start(X3, X4, KEY);
    step();
    step();
    step();
    chk_flags("gap_wait_hi", 4'b0001);
    send(THI);
    step();
    step();
    step();
    chk_flags("gap_wait_lo", 4'b0001);
    send(TLO);
    chk_flags("gap_done", 4'b1100);

    // Timeout with no valid at all.
    do_start(X3, X4, KEY);
    for (int i = 0; i < 7; i++) step();
    chk_flags("tmo_before", 4'b0001);
    step();
    chk_flags("tmo_expired", 4'b1010);
    chk("tmo_tag", tag_o, fail_tag);

    // Handshake on the expiry cycle wins.
    do_start(X3, X4, KEY);
    for (int i = 0; i < 7; i++) step();
    send(THI);
    chk_flags("tmo_edge_accept", 4'b0001);
    send(TLO);
    chk_flags("tmo_edge_done", 4'b1100);

    // Timeout while waiting for the low word: counter restarts after the high word.
    do_start(X3, X4, KEY);
    send(THI);
    for (int i = 0; i < 7; i++) step();
    chk_flags("tmo_lo_before", 4'b0001);
    step();
    chk_flags("tmo_lo_expired", 4'b1010);

    // Reset while in RECV_LO.
    do_start(X3, X4, KEY);
    send(THI);
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    chk_flags("midrst_flags", 4'b0000);
    chk("midrst_tag", tag_o, 128'd0);
    tif.tag_valid = 1'b1;
    tif.tag_data = TLO;
    step();
    tif.tag_valid = 1'b0;
    chk_flags("midrst_idle", 4'b0000);
    do_start(X3, X4, KEY);
    send(THI);
    send(TLO);
    chk_flags("midrst_rerun", 4'b1100);
    chk("midrst_rerun_tag", tag_o, {THI, TLO});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_tag_verify.md
Name: ascon_tag_verify

Overview:
- Decryption-side counterpart of the finalization key XOR.
- Takes the ASCON state after the final p12 permutation and the 128-bit key, and forms the expected tag.
- Receives the transmitted tag as two 64-bit words over a valid/ready handshake and compares in constant time.
- Reports done/ok to the top-level FSM, which gates plaintext release.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles to wait for each tag word after entering a receive state; 0 disables the timeout.

Ports:
- clock_i  input  1  system clock; all logic rising-edge.
- resetb_i  input  1  synchronous active-low reset.
- start_i  input  1  one-cycle pulse; state_i/key_i valid this cycle.
- state_i  input  type_state (5x64)  ASCON state after final permutation.
- key_i  input  128  cipher key.
- tag_data_i  input  64  received tag word, high word first.
- tag_valid_i  input  1  tag_data_i valid.
- tag_ready_o  output  1  block accepts a tag word.
- tag_o  output  128  expected tag {x3^key[127:64], x4^key[63:0]}.
- done_o  output  1  verification finished (level, held until next start_i).
- tag_ok_o  output  1  tags matched; meaningful only when done_o=1.
- error_o  output  1  timeout abort; meaningful only when done_o=1.

Behaviour:
- Reset (resetb_i=0 at a clock edge): FSM=IDLE; tag_o=0, tag_ready_o=0, done_o=0, tag_ok_o=0, error_o=0; diff accumulator=0; timeout counter=0. Reset mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, RECV_HI, RECV_LO, DONE.
- IDLE:
  - On start_i: register tag_o from state_i[3]^key_i[127:64] and state_i[4]^key_i[63:0].
  - Clear the accumulator, counter, done_o, tag_ok_o and error_o.
  - Go to RECV_HI on the next cycle.
- RECV_HI and RECV_LO:
  - tag_ready_o=1 in both states, driven directly from the state register.
  - Handshake occurs when tag_valid_i && tag_ready_o at an edge.
  - On handshake: accumulator |= tag_data_i ^ expected word (tag_o[127:64] in RECV_HI, tag_o[63:0] in RECV_LO); clear the counter; advance RECV_HI->RECV_LO->DONE.
  - tag_valid_i is ignored outside RECV_HI/RECV_LO.
- Timeout:
  - If TIMEOUT_CYC!=0, the counter increments each receive-state cycle without a handshake.
  - When the counter reaches TIMEOUT_CYC-1 without a handshake, go to DONE with error_o=1 and tag_ok_o=0.
  - A handshake on the same cycle as expiry wins; the timeout is not taken.
- DONE:
  - done_o=1.
  - tag_ok_o=1 iff the accumulator==0 and no error; computed only on entering DONE, never early.
  - No early exit on a mismatch in the first word: both words are always consumed, so timing is data-independent.
- start_i in DONE restarts exactly as from IDLE. start_i in RECV_* is ignored.
- Latency: start_i -> tag_ready_o high after 1 cycle; last handshake -> done_o high the next cycle. Minimum 3 cycles start-to-done.

Optional Feature:
- Macro ASCON_TAG_ZEROIZE_EN.
- When defined:
  - On entering DONE with tag_ok_o=0, tag_o and the accumulator are cleared to 0 on the following cycle.
  - tag_o reads 0 whenever FSM is DONE and tag_ok_o=0, so the expected tag never leaks after a failed check.
- When undefined: tag_o holds the expected tag until the next start_i or reset.

Test Plan:
- Match:
  - Stimulus: state_i[3]=c0c4757ca2646459, state_i[4]=f44a7ed98e1d9c83, key=000102030405060708090A0B0C0D0E0F, start.
  - Required: tag_o=c0c5777fa661625e_fc4374d28210928c.
  - Send words c0c5777fa661625e then fc4374d28210928c -> done_o=1, tag_ok_o=1, error_o=0 one cycle after the second handshake.
- Mismatch in high word only:
  - Send c0c5777fa661625f then a correct low word.
  - Required: both words accepted (tag_ready_o high for both), done_o=1, tag_ok_o=0. With ASCON_TAG_ZEROIZE_EN, tag_o=0 one cycle later.
- Backpressure/gaps:
  - tag_valid_i toggles 0/1 with 3 idle cycles between words -> same result as the match case; no double capture.
- Timeout:
  - TIMEOUT_CYC=8, start, never assert valid.
  - Required: done_o=1, error_o=1, tag_ok_o=0 exactly 8 cycles after entering RECV_HI.
  - Valid on the expiry cycle -> word accepted, no error.
- Reset mid-run:
  - resetb_i=0 for 1 cycle while in RECV_LO -> all outputs 0, FSM IDLE.
  - A subsequent start plus the match sequence passes.
- Restart from DONE:
  - After a failed check, start_i with new state -> flags cleared next cycle; new verification succeeds.
